// File: rtl/cpu_pkg.sv
// Shared fetch-side types and constants: PC/instruction widths, reset PC,
// fetch FSM encoding and the {PC, instruction} queue entry.
package cpu_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 16;
  localparam logic [PC_W-1:0] RESET_PC = 8'h00;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_prefetch_unit_if.sv
// Bundle of the instruction-memory read port and the datapath-facing stream.
// master = prefetch unit, slave = memory/datapath environment.
interface instr_prefetch_unit_if #(
  parameter int DEPTH = 4
);
  import cpu_pkg::*;

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               stall;
  logic               flush;
  logic [PC_W-1:0]    branch_target;
  logic [INSTR_W-1:0] instruction;
  logic [PC_W-1:0]    PC_out;
  logic               valid;
  logic [CNT_W-1:0]   count;

  modport master (
    output imem_req, imem_addr, instruction, PC_out, valid, count,
    input  imem_ack, imem_rdata, stall, flush, branch_target
  );

  modport slave (
    input  imem_req, imem_addr, instruction, PC_out, valid, count,
    output imem_ack, imem_rdata, stall, flush, branch_target
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {PC, instruction} with wrapping pointers and an
// occupancy count; clear beats push and pop in the same cycle.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  fetch_entry_t     wr_data,
  output fetch_entry_t     rd_data,
  output logic             valid,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  // The producer never pushes when full, so only empty pops need filtering.
  assign do_push = push & ~clear;
  assign do_pop  = pop & ~clear & (count_reg != '0);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  assign rd_data = mem[rd_ptr_reg];
  assign valid   = (count_reg != '0);
  assign count   = count_reg;

endmodule

// File: rtl/instr_prefetch_unit.sv
// Instruction prefetcher: one outstanding read to a variable-latency memory,
// results queued in fetch_fifo and streamed to decode with stall/flush control.
module instr_prefetch_unit
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  instr_prefetch_unit_if.master bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  fetch_state_e     state_reg, state_next;
  logic [PC_W-1:0]  fetch_pc_reg, fetch_pc_next;
  logic [PC_W-1:0]  addr_reg, addr_next;
  logic             push, pop, fifo_valid;
  logic [CNT_W-1:0] fifo_count, count_after;
  fetch_entry_t     wr_entry, head;

  assign push     = (state_reg == REQ) & bus.imem_ack & ~bus.flush;
  assign pop      = fifo_valid & ~bus.stall;
  assign wr_entry = {fetch_pc_reg, bus.imem_rdata};

  fetch_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .clear   (bus.flush),
    .wr_data (wr_entry),
    .rd_data (head),
    .valid   (fifo_valid),
    .count   (fifo_count)
  );

  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    addr_next     = addr_reg;
    count_after   = fifo_count + CNT_W'(push) - CNT_W'(pop);
    case (state_reg)
      IDLE: begin
        if (!bus.flush && fifo_count < FULL_CNT) begin
          state_next = REQ;
          addr_next  = fetch_pc_reg;
        end
      end
      REQ: begin
        if (bus.flush) begin
          state_next = bus.imem_ack ? IDLE : DISCARD;
        end else if (bus.imem_ack) begin
          fetch_pc_next = fetch_pc_reg + PC_W'(1);
          // Back-to-back issue keeps a zero-wait memory at one word per cycle.
          if (count_after < FULL_CNT) begin
            state_next = REQ;
            addr_next  = fetch_pc_reg + PC_W'(1);
          end else begin
            state_next = IDLE;
          end
        end
      end
      DISCARD: begin
        if (bus.imem_ack) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (bus.flush) begin
      fetch_pc_next = bus.branch_target;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      fetch_pc_reg <= RESET_PC;
      addr_reg     <= RESET_PC;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      addr_reg     <= addr_next;
    end
  end

  // A stale request in DISCARD keeps its original address until acked.
  assign bus.imem_req    = (state_reg != IDLE);
  assign bus.imem_addr   = addr_reg;
  assign bus.valid       = fifo_valid;
  assign bus.count       = fifo_count;
  assign bus.instruction = fifo_valid ? head.instr : '0;
  assign bus.PC_out      = fifo_valid ? head.pc : '0;

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Randomized bench for instr_prefetch_unit against a queue-based model of the
// expected instruction stream, plus directed latency/full/flush/wrap/reset checks.
module tb_instr_prefetch_unit;
  import cpu_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;

  instr_prefetch_unit_if #(.DEPTH(DEPTH)) bus ();

  instr_prefetch_unit #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [INSTR_W-1:0] mem_img [256];
  logic [PC_W-1:0]    m_q [$];
  logic [PC_W-1:0]    m_fetch_pc;
  logic [PC_W-1:0]    seen [$];
  bit                 m_stale;
  int                 lat;
  int                 wait_cnt;
  int                 n_pops;
  bit                 prev_req;
  bit                 prev_ack;
  logic [PC_W-1:0]    prev_addr;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_fetch_pc = RESET_PC;
    m_stale    = 1'b0;
    wait_cnt   = 0;
    prev_req   = 1'b0;
    prev_ack   = 1'b0;
    prev_addr  = '0;
    n_pops     = 0;
  endtask

  // Entered at a negedge: check outputs, act as memory, drive inputs,
  // advance the model across the coming posedge, move to the next negedge.
  task automatic cycle(input bit st, input bit fl, input logic [PC_W-1:0] tgt);
    bit req, ack, push, pop;
    req = bus.imem_req;
    check_eq("count", 32'(bus.count), m_q.size());
    check_eq("valid", 32'(bus.valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      check_eq("pc_out", 32'(bus.PC_out), 32'(m_q[0]));
      check_eq("instr", 32'(bus.instruction), 32'(mem_img[m_q[0]]));
    end else begin
      check_eq("pc_out_empty", 32'(bus.PC_out), 0);
      check_eq("instr_empty", 32'(bus.instruction), 0);
    end
    if (prev_req && !prev_ack) begin
      check_eq("req_held", 32'(req), 1);
      check_eq("addr_stable", 32'(bus.imem_addr), 32'(prev_addr));
    end
    if (req) ack = (wait_cnt >= lat);
    else     ack = ($urandom_range(0, 1) == 1);
    bus.imem_ack      = ack;
    bus.imem_rdata    = (req && ack) ? mem_img[bus.imem_addr] : 16'($urandom);
    bus.stall         = st;
    bus.flush         = fl;
    bus.branch_target = tgt;
    if (req && ack && !m_stale) begin
      check_eq("fetch_addr", 32'(bus.imem_addr), 32'(m_fetch_pc));
    end
    push = req && ack && !m_stale && !fl;
    pop  = (m_q.size() != 0) && !st;
    prev_req  = req;
    prev_ack  = ack;
    prev_addr = bus.imem_addr;
    if (req) wait_cnt = ack ? 0 : wait_cnt + 1;
    if (fl) begin
      m_q.delete();
      m_fetch_pc = tgt;
      m_stale    = req && !ack;
    end else begin
      if (pop) begin
        void'(m_q.pop_front());
        n_pops++;
      end
      if (push) begin
        m_q.push_back(m_fetch_pc);
        m_fetch_pc = m_fetch_pc + 8'd1;
      end
      if (req && ack) m_stale = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset             = 1'b0;
    bus.imem_ack      = 1'b0;
    bus.imem_rdata    = '0;
    bus.stall         = 1'b0;
    bus.flush         = 1'b0;
    bus.branch_target = '0;
    @(negedge clk);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem_img[i] = 16'($urandom);
    lat = 0;
    bus.imem_ack      = 1'b0;
    bus.imem_rdata    = '0;
    bus.stall         = 1'b0;
    bus.flush         = 1'b0;
    bus.branch_target = '0;
    model_reset();

    // Reset values
    repeat (2) @(negedge clk);
    check_eq("rst_req", 32'(bus.imem_req), 0);
    check_eq("rst_addr", 32'(bus.imem_addr), 32'(RESET_PC));
    check_eq("rst_valid", 32'(bus.valid), 0);
    check_eq("rst_count", 32'(bus.count), 0);
    check_eq("rst_instr", 32'(bus.instruction), 0);
    check_eq("rst_pc_out", 32'(bus.PC_out), 0);
    reset = 1'b1;

    // 1: zero-wait memory, no stall
    for (int k = 1; k <= 20; k++) begin
      cycle(1'b0, 1'b0, 8'h00);
      check_eq("t1_valid_from_cycle2", 32'(bus.valid), 32'(k >= 2));
    end
    check_eq("t1_throughput", 32'(n_pops >= 18), 1);

    // 2: three-cycle memory latency
    lat = 3;
    n_pops = 0;
    for (int k = 0; k < 40; k++) cycle(1'b0, 1'b0, 8'h00);
    check_eq("t2_progress", 32'(n_pops >= 7), 1);

    // 3: stall fills the queue, then drains in order
    lat = 0;
    do_reset();
    for (int k = 0; k < 10; k++) cycle(1'b1, 1'b0, 8'h00);
    check_eq("t3_full", 32'(bus.count), DEPTH);
    check_eq("t3_req_off", 32'(bus.imem_req), 0);
    check_eq("t3_head", 32'(bus.PC_out), 32'(RESET_PC));
    for (int k = 0; k < 10; k++) cycle(1'b0, 1'b0, 8'h00);

    // 4: flush while a request is outstanding
    lat = 2;
    do_reset();
    for (int k = 0; k < 20 && !(bus.imem_req && wait_cnt == 0); k++) cycle(1'b0, 1'b0, 8'h00);
    check_eq("t4_req_pending", 32'(bus.imem_req), 1);
    cycle(1'b0, 1'b1, 8'h40);
    for (int k = 0; k < 30 && !bus.valid; k++) cycle(1'b0, 1'b0, 8'h00);
    check_eq("t4_valid_seen", 32'(bus.valid), 1);
    check_eq("t4_first_pc", 32'(bus.PC_out), 32'h40);

    // 5: flush together with ack and pop
    lat = 0;
    for (int k = 0; k < 5; k++) cycle(1'b0, 1'b0, 8'h00);
    check_eq("t5_busy", 32'(bus.valid && bus.imem_req), 1);
    cycle(1'b0, 1'b1, 8'h80);
    check_eq("t5_count", 32'(bus.count), 0);
    check_eq("t5_valid", 32'(bus.valid), 0);
    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 8'h00);
    check_eq("t5_first_pc", 32'(bus.PC_out), 32'h80);

    // 6: PC wrap, then asynchronous reset mid-stream
    cycle(1'b0, 1'b1, 8'hFE);
    seen.delete();
    for (int k = 0; k < 10; k++) begin
      if (bus.valid) seen.push_back(bus.PC_out);
      cycle(1'b0, 1'b0, 8'h00);
    end
    check_eq("t6_seen_len", 32'(seen.size() >= 4), 1);
    if (seen.size() >= 4) begin
      check_eq("t6_pc0", 32'(seen[0]), 32'hFE);
      check_eq("t6_pc1", 32'(seen[1]), 32'hFF);
      check_eq("t6_pc2", 32'(seen[2]), 32'h00);
      check_eq("t6_pc3", 32'(seen[3]), 32'h01);
    end
    check_eq("t6_pre_req", 32'(bus.imem_req), 1);
    #2;
    reset = 1'b0;
    #1;
    check_eq("t6_arst_req", 32'(bus.imem_req), 0);
    check_eq("t6_arst_addr", 32'(bus.imem_addr), 32'(RESET_PC));
    check_eq("t6_arst_valid", 32'(bus.valid), 0);
    check_eq("t6_arst_count", 32'(bus.count), 0);
    check_eq("t6_arst_instr", 32'(bus.instruction), 0);
    check_eq("t6_arst_pc_out", 32'(bus.PC_out), 0);
    do_reset();

    // Random traffic: latency, stall and flush all varied
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 7) == 0) lat = $urandom_range(0, 3);
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, 8'($urandom));
    end
    check_eq("rand_progress", 32'(n_pops > 50), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
